// File: rtl/microseq_dispatch.sv
// Microprogram sequencer with priority-encoded opcode dispatch table, bounded return stack and FAULT state.
// Optional trace outputs (last_op, dispatch_cnt) are enabled by defining MICROSEQ_DISPATCH_TRACE_EN.
module microseq_dispatch #(
    parameter int N_OPS        = 32,
    parameter int ADDR_W       = 8,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_ADDR   = 0,
    parameter int DEFAULT_ADDR = 0,
    parameter int FAULT_ADDR   = 255,
    parameter int MAP_BASE     = 20,
    localparam int IDX_W       = $clog2(N_OPS),
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_OPS-1:0]  op_vec,
    input  logic [2:0]        seq_ctl,
    input  logic              cond,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              stall,
    input  logic              err_clr,
    input  logic              map_we,
    input  logic [IDX_W-1:0]  map_idx,
    input  logic [ADDR_W-1:0] map_data,
    output logic [ADDR_W-1:0] upc,
    output logic              map_hit,
    output logic              stack_err,
    output logic [SP_W-1:0]   sp,
`ifdef MICROSEQ_DISPATCH_TRACE_EN
    output logic [IDX_W-1:0]  last_op,
    output logic [15:0]       dispatch_cnt,
`endif
    output logic              dbg_state
);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    localparam logic [2:0] C_INC  = 3'd0;
    localparam logic [2:0] C_BR   = 3'd1;
    localparam logic [2:0] C_BRC  = 3'd2;
    localparam logic [2:0] C_MAP  = 3'd3;
    localparam logic [2:0] C_CALL = 3'd4;
    localparam logic [2:0] C_RET  = 3'd5;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_upc, w_upc_nx;
    logic [SP_W-1:0]   r_sp, w_sp_nx;
    logic              r_map_hit, w_hit_nx;
    logic              w_push;
    logic [ADDR_W-1:0] r_table [N_OPS];
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [IDX_W-1:0]  w_op_idx;
    logic              w_op_any;
    logic              w_map_ok;
    logic [ADDR_W-1:0] w_upc_inc;

    assign w_upc_inc = r_upc + ADDR_W'(1);

    // Descending scan so the lowest set bit is the last one assigned.
    always_comb begin
        w_op_idx = '0;
        for (int i = N_OPS - 1; i >= 0; i--) begin
            if (op_vec[i]) w_op_idx = IDX_W'(i);
        end
    end
    assign w_op_any = |op_vec;

    always_comb begin
        w_state_nx = r_state;
        w_upc_nx   = r_upc;
        w_sp_nx    = r_sp;
        w_hit_nx   = r_map_hit;
        w_push     = 1'b0;
        w_map_ok   = 1'b0;
        case (r_state)
            RUN: begin
                if (!stall) begin
                    w_hit_nx = 1'b0;
                    case (seq_ctl)
                        C_INC: w_upc_nx = w_upc_inc;
                        C_BR:  w_upc_nx = br_addr;
                        C_BRC: w_upc_nx = cond ? br_addr : w_upc_inc;
                        C_MAP: begin
                            if (w_op_any) begin
                                w_upc_nx = r_table[w_op_idx];
                                w_hit_nx = 1'b1;
                                w_map_ok = 1'b1;
                            end else begin
                                w_upc_nx = ADDR_W'(DEFAULT_ADDR);
                            end
                        end
                        C_CALL: begin
                            if (r_sp < SP_W'(STACK_DEPTH)) begin
                                w_push   = 1'b1;
                                w_sp_nx  = r_sp + SP_W'(1);
                                w_upc_nx = br_addr;
                            end else begin
                                w_state_nx = FAULT;
                            end
                        end
                        C_RET: begin
                            if (r_sp != '0) begin
                                w_sp_nx  = r_sp - SP_W'(1);
                                w_upc_nx = r_stack[r_sp - SP_W'(1)];
                            end else begin
                                w_state_nx = FAULT;
                            end
                        end
                        default: w_upc_nx = r_upc;
                    endcase
                    if (w_state_nx == FAULT) begin
                        w_upc_nx = ADDR_W'(FAULT_ADDR);
                        w_sp_nx  = '0;
                        w_hit_nx = 1'b0;
                    end
                end
            end
            FAULT: begin
                // upc stays parked at FAULT_ADDR across the recovery edge too.
                w_upc_nx = ADDR_W'(FAULT_ADDR);
                w_sp_nx  = '0;
                w_hit_nx = 1'b0;
                if (err_clr) w_state_nx = RUN;
            end
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_upc     <= ADDR_W'(RESET_ADDR);
            r_sp      <= '0;
            r_map_hit <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_upc     <= w_upc_nx;
            r_sp      <= w_sp_nx;
            r_map_hit <= w_hit_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OPS; i++) r_table[i] <= ADDR_W'(MAP_BASE + i);
        end else if (map_we && (32'(map_idx) < 32'(N_OPS))) begin
            r_table[map_idx] <= map_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp[$clog2(STACK_DEPTH)-1:0]] <= w_upc_inc;
    end

`ifdef MICROSEQ_DISPATCH_TRACE_EN
    logic [IDX_W-1:0] r_last_op;
    logic [15:0]      r_dispatch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_op      <= '0;
            r_dispatch_cnt <= '0;
        end else if (w_map_ok) begin
            r_last_op <= w_op_idx;
            if (r_dispatch_cnt != 16'hFFFF) r_dispatch_cnt <= r_dispatch_cnt + 16'd1;
        end
    end

    assign last_op      = r_last_op;
    assign dispatch_cnt = r_dispatch_cnt;
`endif

    assign upc       = r_upc;
    assign map_hit   = r_map_hit;
    assign stack_err = (r_state == FAULT);
    assign sp        = r_sp;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_microseq_dispatch.sv
// Directed self-checking bench for microseq_dispatch with hand-computed expected values.
// Trace outputs are checked too when MICROSEQ_DISPATCH_TRACE_EN is defined.
module tb_microseq_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_vec;
    logic [2:0]  seq_ctl;
    logic        cond;
    logic [7:0]  br_addr;
    logic        stall;
    logic        err_clr;
    logic        map_we;
    logic [4:0]  map_idx;
    logic [7:0]  map_data;
    logic [7:0]  upc;
    logic        map_hit;
    logic        stack_err;
    logic [2:0]  sp;
    logic        dbg_state;
`ifdef MICROSEQ_DISPATCH_TRACE_EN
    logic [4:0]  last_op;
    logic [15:0] dispatch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] INC = 3'd0, BR = 3'd1, BRC = 3'd2, MAP = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HOLD = 3'd6;

    microseq_dispatch dut (
        .clk       (clk),
        .rst       (rst),
        .op_vec    (op_vec),
        .seq_ctl   (seq_ctl),
        .cond      (cond),
        .br_addr   (br_addr),
        .stall     (stall),
        .err_clr   (err_clr),
        .map_we    (map_we),
        .map_idx   (map_idx),
        .map_data  (map_data),
        .upc       (upc),
        .map_hit   (map_hit),
        .stack_err (stack_err),
        .sp        (sp),
`ifdef MICROSEQ_DISPATCH_TRACE_EN
        .last_op      (last_op),
        .dispatch_cnt (dispatch_cnt),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sequencing command for one clock, then settle past the edge.
    task automatic step(input logic [2:0] ctl, input logic [7:0] addr);
        seq_ctl = ctl;
        br_addr = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        op_vec = '0; seq_ctl = INC; cond = 1'b0; br_addr = '0; stall = 1'b0;
        err_clr = 1'b0; map_we = 1'b0; map_idx = '0; map_data = '0;
        do_reset();
        check("rst_upc", upc, 0);
        check("rst_sp", sp, 0);
        check("rst_hit", map_hit, 0);
        check("rst_err", stack_err, 0);

        for (int i = 1; i <= 3; i++) begin
            step(INC, 0);
            check("inc_upc", upc, i);
        end
        step(BR, 8'd255);
        check("br_255", upc, 255);
        step(INC, 0);
        check("inc_wrap", upc, 0);

        cond = 1'b0; step(BRC, 8'd40);
        check("brc_false", upc, 1);
        cond = 1'b1; step(BRC, 8'd40);
        check("brc_true", upc, 40);
        cond = 1'b0;

        op_vec = 32'h0000_0014; step(MAP, 0);
        check("map_prio_upc", upc, 22);
        check("map_prio_hit", map_hit, 1);
`ifdef MICROSEQ_DISPATCH_TRACE_EN
        check("trace_last_op", last_op, 2);
        check("trace_cnt", dispatch_cnt, 1);
`endif
        op_vec = 32'h0; step(MAP, 0);
        check("map_zero_upc", upc, 0);
        check("map_zero_hit", map_hit, 0);
`ifdef MICROSEQ_DISPATCH_TRACE_EN
        check("trace_cnt_zero", dispatch_cnt, 1);
`endif

        op_vec = 32'h0000_0010; map_we = 1'b1; map_idx = 5'd4; map_data = 8'h80;
        step(MAP, 0);
        map_we = 1'b0;
        check("map_old_val", upc, 24);
        step(MAP, 0);
        check("map_new_val", upc, 8'h80);
        op_vec = 32'h8000_0000; step(MAP, 0);
        check("map_top_entry", upc, 51);
        step(HOLD, 0);
        check("hold_upc", upc, 51);
        check("hold_hit", map_hit, 0);
        step(3'd7, 0);
        check("rsv_upc", upc, 51);

        step(BR, 8'd10);
        step(CALL, 8'd50);
        check("call_upc", upc, 50);
        check("call_sp", sp, 1);
        step(RET, 0);
        check("ret_upc", upc, 11);
        check("ret_sp", sp, 0);

        for (int i = 1; i <= 4; i++) begin
            step(CALL, 8'(100 + i));
            check("call_n_sp", sp, i);
        end
        step(RET, 0);
        check("ret_lifo", upc, 104);
        step(CALL, 8'd104);
        step(CALL, 8'd120);
        check("ovf_upc", upc, 255);
        check("ovf_err", stack_err, 1);
        check("ovf_sp", sp, 0);
        check("ovf_state", dbg_state, 1);
        step(CALL, 8'd7);
        check("fault_ignore", upc, 255);
        check("fault_err", stack_err, 1);
        err_clr = 1'b1; step(INC, 0); err_clr = 1'b0;
        check("clr_err", stack_err, 0);
        check("clr_upc", upc, 255);
        step(INC, 0);
        check("clr_resume", upc, 0);

        err_clr = 1'b1; step(INC, 0); err_clr = 1'b0;
        check("clr_in_run", upc, 1);
        step(RET, 0);
        check("unf_upc", upc, 255);
        check("unf_err", stack_err, 1);
        err_clr = 1'b1; step(INC, 0); err_clr = 1'b0;
        step(INC, 0);
        check("unf_resume", upc, 0);

        stall = 1'b1;
        step(BR, 8'd77);
        check("stall_1", upc, 0);
        step(BR, 8'd77);
        check("stall_2", upc, 0);
        stall = 1'b0;
        step(BR, 8'd77);
        check("stall_rel", upc, 77);

        map_we = 1'b1; map_idx = 5'd2; map_data = 8'd5; step(HOLD, 0); map_we = 1'b0;
        do_reset();
        check("mid_rst_upc", upc, 0);
        op_vec = 32'h0000_0004; step(MAP, 0);
        check("mid_rst_table", upc, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
